// File: rtl/hd63701_pkg.sv
// Shared definitions for the HD63701 on-chip peripherals: TCSR layout,
// IRQ2-class vector nibbles and the interrupt-arbiter state encoding.
package hd63701_pkg;

  localparam int TCSR_ICF  = 7;
  localparam int TCSR_OCF  = 6;
  localparam int TCSR_TOF  = 5;
  localparam int TCSR_EICI = 4;
  localparam int TCSR_EOCI = 3;
  localparam int TCSR_ETOI = 2;
  localparam int TCSR_IEDG = 1;
  localparam int TCSR_OLVL = 0;

  localparam logic [3:0] IV_ICF = 4'h6;
  localparam logic [3:0] IV_OCF = 4'h4;
  localparam logic [3:0] IV_TOF = 4'h2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ASRT = 2'd1,
    GAP  = 2'd2
  } irq_state_e;

  // One-hot winner of a 3-source request, bit 2 has the highest priority.
  function automatic logic [2:0] prio_pick(input logic [2:0] req);
    logic [2:0] pick;
    if (req[2]) begin
      pick = 3'b100;
    end else if (req[1]) begin
      pick = 3'b010;
    end else if (req[0]) begin
      pick = 3'b001;
    end else begin
      pick = 3'b000;
    end
    return pick;
  endfunction

endpackage

// File: rtl/hd63701_irq_arb.sv
// Three-source fixed-priority arbiter that turns level requests into the
// edge-sensitive IRQ2/IRQ2V pair, with a forced low gap between requests.
module hd63701_irq_arb
  import hd63701_pkg::*;
#(
  parameter logic [3:0] IV_HI  = IV_ICF,
  parameter logic [3:0] IV_MID = IV_OCF,
  parameter logic [3:0] IV_LO  = IV_TOF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] req,
  input  logic       vack,
  output logic       irq,
  output logic [3:0] irqv
);

  irq_state_e state_r, state_n;
  logic [2:0] src_r, src_n;
  logic [2:0] pick_s;
  logic [3:0] irqv_r, irqv_n;
  logic       irq_r;

  // Next-state logic; the latched source is held until it retires or is acked.
  always_comb begin
    state_n = state_r;
    src_n   = src_r;
    irqv_n  = irqv_r;
    pick_s  = prio_pick(req);
    case (state_r)
      IDLE: begin
        if (req != 3'b000) begin
          src_n   = pick_s;
          irqv_n  = pick_s[2] ? IV_HI : (pick_s[1] ? IV_MID : IV_LO);
          state_n = ASRT;
        end else begin
          state_n = IDLE;
        end
      end
      ASRT: begin
        if (vack || ((req & src_r) == 3'b000)) begin
          state_n = GAP;
        end else begin
          state_n = ASRT;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      src_r   <= 3'b000;
      irqv_r  <= 4'h0;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      src_r   <= src_n;
      irqv_r  <= irqv_n;
      irq_r   <= (state_n == ASRT);
    end
  end

  assign irq  = irq_r;
  assign irqv = irqv_r;

endmodule

// File: rtl/hd63701_tim_irq.sv
// Free-running-timer interrupt source: TCSR flags/enables, the
// read-then-access flag clear sequence, and IRQ2 arbitration.
module hd63701_tim_irq
  import hd63701_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ICF_SET,
  input  logic       OCF_SET,
  input  logic       TOF_SET,
  input  logic       TCSR_WR,
  input  logic       TCSR_RD,
  input  logic       ICR_RD,
  input  logic       OCR_WR,
  input  logic       FRC_RD,
  input  logic       VACK,
  input  logic [7:0] DI,
  output logic [7:0] TCSR_DO,
  output logic       IRQ2,
  output logic [3:0] IRQ2V,
  output logic       IEDG,
  output logic       OLVL
);

  // Flag vectors are ordered {ICF, OCF, TOF}, matching TCSR bits 7..5.
  logic [2:0] flag_r, flag_n;
  logic [2:0] arm_r, arm_n;
  logic [4:0] ctl_r, ctl_n;
  logic [2:0] set_s, acc_s, qclr_s, req_s;

  assign set_s  = {ICF_SET, OCF_SET, TOF_SET};
  assign acc_s  = {ICR_RD, OCR_WR, FRC_RD};
  assign qclr_s = acc_s & arm_r;

  // Flag/arm/control next values; a set strobe overrides a same-cycle clear.
  always_comb begin
    flag_n = (flag_r & ~qclr_s) | set_s;
    if (TCSR_RD) begin
      arm_n = (arm_r | flag_r) & ~qclr_s;
    end else begin
      arm_n = arm_r & ~qclr_s;
    end
    if (TCSR_WR) begin
      ctl_n = DI[4:0];
    end else begin
      ctl_n = ctl_r;
    end
  end

  // TCSR register state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flag_r <= 3'b000;
      arm_r  <= 3'b000;
      ctl_r  <= 5'b00000;
    end else begin
      flag_r <= flag_n;
      arm_r  <= arm_n;
      ctl_r  <= ctl_n;
    end
  end

  assign req_s   = flag_r & ctl_r[TCSR_EICI:TCSR_ETOI];
  assign TCSR_DO = {flag_r, ctl_r};
  assign IEDG    = ctl_r[TCSR_IEDG];
  assign OLVL    = ctl_r[TCSR_OLVL];

  hd63701_irq_arb #(
    .IV_HI  (IV_ICF),
    .IV_MID (IV_OCF),
    .IV_LO  (IV_TOF)
  ) u_arb (
    .CLK   (CLK),
    .RST_N (RST_N),
    .req   (req_s),
    .vack  (VACK),
    .irq   (IRQ2),
    .irqv  (IRQ2V)
  );

endmodule
